booth_radix4_seq_mult: RTL and testbench

BOOTH_RADIX4_SEQ_MULT -- requirements
Module: booth_radix4_seq_mult

---
 rtl/booth_radix4_seq_mult.sv | 84 ++++++++
 tb/tb_booth_radix4_seq_mult.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult: sequential radix-4 Booth multiplier, one digit per cycle,
// signed or unsigned operands, valid/ready handshakes on both sides.
// Optional feature: define BOOTH_R4_EARLY_TERM_EN to finish as soon as the remaining
// Booth digits are all zero.
module booth_radix4_seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);
    localparam int K  = N / 2 + 1;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [2*N+1:0]    m_sh, acc, pp, acc_next;
    logic [N+2:0]      b_sh;
    logic [CW-1:0]     cnt;
    logic [2:0]        w;
    logic              last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Booth digit decode of the current window and the partial-product add
    always_comb begin
        w        = b_sh[2:0];
        pp       = (w == 3'b001 || w == 3'b010) ? m_sh :
                   (w == 3'b011)                ? (m_sh << 1) :
                   (w == 3'b100)                ? -(m_sh << 1) :
                   (w == 3'b101 || w == 3'b110) ? -m_sh : '0;
        acc_next = acc + pp;
`ifdef BOOTH_R4_EARLY_TERM_EN
        last     = (cnt == CW'(K - 1)) || (b_sh[N+2:2] == '0) || (&b_sh[N+2:2]);
`else
        last     = (cnt == CW'(K - 1));
`endif
    end

    // Next-state selection for the IDLE -> CALC -> DONE handshake loop
    always_comb begin
        state_next = state;
        state_next = (state == IDLE && in_valid)  ? CALC :
                     (state == CALC && last)      ? DONE :
                     (state == DONE && out_ready) ? IDLE : state;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture, digit iteration (multiplicand weight grows by 4 per digit) and result latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid) begin
            m_sh    <= {{(N+2){is_signed & multiplicand[N-1]}}, multiplicand};
            b_sh    <= {{2{is_signed & multiplier[N-1]}}, multiplier, 1'b0};
            acc     <= '0;
            cnt     <= '0;
        end else if (state == CALC) begin
            acc     <= acc_next;
            m_sh    <= m_sh << 2;
            b_sh    <= {{2{b_sh[N+2]}}, b_sh[N+2:2]};
            cnt     <= cnt + 1'b1;
            if (last) product <= acc_next[2*N-1:0];
        end
    end
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// tb_booth_radix4_seq_mult: directed-vector bench for booth_radix4_seq_mult (N=8).
module tb_booth_radix4_seq_mult;
    localparam int N = 8;
`ifdef BOOTH_R4_EARLY_TERM_EN
    localparam int LAT = -1;
    localparam int GAP = 4;
`else
    localparam int LAT = 5;
    localparam int GAP = 7;
`endif

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   multiplicand = '0;
    logic [N-1:0]   multiplier = '0;
    logic           is_signed = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs[11] = '{
        '{8'd5,   8'd3,   1'b1, 16'd15},
        '{8'd5,   8'hFD,  1'b1, 16'hFFF1},
        '{8'hFB,  8'd3,   1'b1, 16'hFFF1},
        '{8'hFB,  8'hFD,  1'b1, 16'd15},
        '{8'h80,  8'h80,  1'b1, 16'h4000},
        '{8'h80,  8'hFF,  1'b1, 16'h0080},
        '{8'hFF,  8'hFF,  1'b0, 16'hFE01},
        '{8'h80,  8'd2,   1'b0, 16'h0100},
        '{8'hFF,  8'hFF,  1'b1, 16'h0001},
        '{8'd200, 8'd100, 1'b0, 16'h4E20},
        '{8'h7F,  8'h80,  1'b1, 16'hC080}
    };

    booth_radix4_seq_mult #(.N(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present one operand pair for exactly one accepting edge, then scramble the inputs
    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        chk("accept_rdy", {31'd0, in_ready}, 32'd1);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        is_signed    = 1'($urandom);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp, input int lat);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        if (lat >= 0) chk({tag, "_lat"}, n, lat);
        chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp});
    endtask

    task automatic consume(input logic [15:0] exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_rdy", {31'd0, in_ready}, 32'd1);
        chk("idle_hold", {16'd0, product}, {16'd0, exp});
    endtask

    initial begin
        int acc_t[$];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_done($sformatf("vec%0d", i), vecs[i].p, LAT);
            consume(vecs[i].p);
        end

`ifdef BOOTH_R4_EARLY_TERM_EN
        start(8'd5, 8'd3, 1'b1);
        wait_done("et_5x3", 16'd15, 2);
        consume(16'd15);
        start(8'd5, 8'hFF, 1'b1);
        wait_done("et_5xm1", 16'hFFFB, 1);
        consume(16'hFFFB);
`endif

        // consumer stalls in DONE while in_valid pulses arrive
        start(8'h9C, 8'd50, 1'b1);
        wait_done("hold", 16'hEC78, LAT);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid     = ~in_valid;
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            @(posedge clk);
            #1;
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_prod", {16'd0, product}, 32'h0000EC78);
            chk("hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume(16'hEC78);
        @(posedge clk);
        #1;
        chk("no_queue_rdy", {31'd0, in_ready}, 32'd1);
        chk("no_queue_vld", {31'd0, out_valid}, 32'd0);

        // reset in the third CALC cycle aborts the operation
        start(8'h64, 8'hB3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rdy", {31'd0, in_ready}, 32'd1);
        chk("abort_vld", {31'd0, out_valid}, 32'd0);
        chk("abort_prod", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_vld", {31'd0, out_valid}, 32'd0);
        start(8'd12, 8'd7, 1'b0);
        wait_done("post_rst", 16'd84, LAT);
        consume(16'd84);

        // back-to-back with both handshakes tied high
        @(negedge clk);
        multiplicand = 8'd9;
        multiplier   = 8'hF9;
        is_signed    = 1'b1;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        for (int c = 0; c < 3 * GAP + 3; c++) begin
            if (in_ready) acc_t.push_back(c);
            if (out_valid) chk("b2b_prod", {16'd0, product}, 32'h0000FFC1);
            @(negedge clk);
        end
        chk("b2b_count", acc_t.size(), 4);
        for (int i = 1; i < acc_t.size(); i++) chk("b2b_gap", acc_t[i] - acc_t[i-1], GAP);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
